// File: rtl/pfd_tdc_if.sv
// Pin bundle between the ADPLL loop and the clocked PFD/TDC.
// The loop side drives the clocks and enable, the detector returns its results.
interface pfd_tdc_if #(
  parameter int CNT_W = 8
);
  logic                    enable;
  logic                    ref_in;
  logic                    fb_in;
  logic                    flagu;
  logic                    flagd;
  logic signed [CNT_W-1:0] err;
  logic                    err_valid;
  logic                    slip;
  logic                    lock;

  modport master (
    output enable,
    output ref_in,
    output fb_in,
    input  flagu,
    input  flagd,
    input  err,
    input  err_valid,
    input  slip,
    input  lock
  );

  modport slave (
    input  enable,
    input  ref_in,
    input  fb_in,
    output flagu,
    output flagd,
    output err,
    output err_valid,
    output slip,
    output lock
  );
endinterface

// File: rtl/pfd_tdc.sv
// Clocked phase/frequency detector with counter TDC and lock detector.
// Measures signed ref-to-fb rising-edge distance in clk cycles.
module pfd_tdc #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input logic       clk,
  input logic       rst_n,
  pfd_tdc_if.slave  bus
);
  localparam int MW = CNT_W - 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  // all-ones magnitude is the symmetric saturation value
  localparam logic [MW-1:0] SAT = '1;
  localparam logic [MW-1:0] ONE = MW'(1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_CNT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DN   = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] f_sync;
  logic                   r_last;
  logic                   f_last;
  logic                   r_rise;
  logic                   f_rise;

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [MW-1:0] cnt;
  logic [MW-1:0] cnt_nxt;
  logic [MW-1:0] cnt_inc;
  logic [MW-1:0] mag;
  logic          emit;
  logic          neg;
  logic          slip_nxt;
  logic          lead_e;
  logic          lag_e;

  logic [CNT_W-1:0] mag_ext;
  logic [CNT_W-1:0] err_word;
  logic             good;
  logic [LW-1:0]    lcnt;
  logic [LW-1:0]    lcnt_inc;

  logic             flagu_q;
  logic             flagd_q;
  logic [CNT_W-1:0] err_q;
  logic             valid_q;
  logic             slip_q;
  logic             lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      f_sync <= '0;
      r_last <= 1'b0;
      f_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ref_in};
      f_sync <= {f_sync[SYNC_STAGES-2:0], bus.fb_in};
      r_last <= r_sync[SYNC_STAGES-1];
      f_last <= f_sync[SYNC_STAGES-1];
    end
  end

  assign r_rise = r_sync[SYNC_STAGES-1] & ~r_last;
  assign f_rise = f_sync[SYNC_STAGES-1] & ~f_last;

  // in DN the feedback edge leads and the reference edge closes
  assign lead_e  = (state == DN) ? f_rise : r_rise;
  assign lag_e   = (state == DN) ? r_rise : f_rise;
  assign cnt_inc = (cnt == SAT) ? SAT : cnt + ONE;

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    emit     = 1'b0;
    neg      = 1'b0;
    mag      = '0;
    slip_nxt = 1'b0;
    unique case (1'b1)
      (state == UP),
      (state == DN): begin
        neg = (state == DN);
        if (lag_e) begin
          emit = 1'b1;
          mag  = cnt;
          if (lead_e) begin
            cnt_nxt = ONE;
          end else begin
            nxt     = IDLE;
            cnt_nxt = '0;
          end
        end else if (lead_e) begin
          emit     = 1'b1;
          mag      = SAT;
          slip_nxt = 1'b1;
          cnt_nxt  = ONE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt = '0;
        nxt     = IDLE;
        if (r_rise & f_rise) begin
          emit = 1'b1;
        end else if (r_rise) begin
          nxt     = UP;
          cnt_nxt = ONE;
        end else if (f_rise) begin
          nxt     = DN;
          cnt_nxt = ONE;
        end
      end
    endcase
  end

  assign mag_ext  = {1'b0, mag};
  assign err_word = neg ? (~mag_ext + 1'b1) : mag_ext;
  assign good     = emit & ~slip_nxt & (int'(mag) <= LOCK_TOL);
  assign lcnt_inc = (lcnt == LMAX) ? LMAX : lcnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      flagu_q <= 1'b0;
      flagd_q <= 1'b0;
      err_q   <= '0;
      valid_q <= 1'b0;
      slip_q  <= 1'b0;
      lcnt    <= '0;
      lock_q  <= 1'b0;
    end else if (!bus.enable) begin
      state   <= IDLE;
      cnt     <= '0;
      flagu_q <= 1'b0;
      flagd_q <= 1'b0;
      valid_q <= 1'b0;
      slip_q  <= 1'b0;
      lcnt    <= '0;
      lock_q  <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      flagu_q <= (nxt == UP);
      flagd_q <= (nxt == DN);
      valid_q <= emit;
      slip_q  <= slip_nxt;
      if (emit) begin
        err_q <= err_word;
        if (good) begin
          lcnt   <= lcnt_inc;
          lock_q <= (lcnt_inc == LMAX);
        end else begin
          lcnt   <= '0;
          lock_q <= 1'b0;
        end
      end
    end
  end

  assign bus.flagu     = flagu_q;
  assign bus.flagd     = flagd_q;
  assign bus.err       = $signed(err_q);
  assign bus.err_valid = valid_q;
  assign bus.slip      = slip_q;
  assign bus.lock      = lock_q;
endmodule

// File: tb/tb_pfd_tdc.sv
// Scoreboard bench for pfd_tdc: timestamp-based window model feeds a queue,
// a negedge monitor pops on err_valid and compares.
module tb_pfd_tdc;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int TOL   = 2;
  localparam int LCNT  = 16;
  localparam int SAT   = (1 << (CNT_W - 1)) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pfd_tdc_if #(.CNT_W(CNT_W)) bus();

  pfd_tdc #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .LOCK_TOL   (TOL),
    .LOCK_CNT   (LCNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    bit s;
    bit l;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t mon_e;

  // model: open window direction (+1 ref leads, -1 fb leads, 0 none)
  int now    = 0;
  int open   = 0;
  int t_open = 0;
  int m_err  = 0;
  int lgood  = 0;
  bit m_lock = 0;
  bit r_prev = 0;
  bit f_prev = 0;
  bit rdly[$];
  bit fdly[$];
  bit re, fe, lead_e, lag_e;
  int el;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void emit(int v, bit s);
    int a;
    a = (v < 0) ? -v : v;
    m_err = v;
    if (!s && a <= TOL) lgood = (lgood < LCNT) ? lgood + 1 : LCNT;
    else lgood = 0;
    m_lock = (lgood == LCNT);
    sbq.push_back('{v, s, m_lock});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now = 0; open = 0; t_open = 0; m_err = 0;
      lgood = 0; m_lock = 0; r_prev = 0; f_prev = 0;
      rdly.delete(); fdly.delete(); sbq.delete();
    end else begin
      now++;
      rdly.push_back(bus.ref_in & ~r_prev);
      fdly.push_back(bus.fb_in & ~f_prev);
      r_prev = bus.ref_in;
      f_prev = bus.fb_in;
      re = 0;
      fe = 0;
      if (rdly.size() > SYNC) begin
        re = rdly.pop_front();
        fe = fdly.pop_front();
      end
      if (!bus.enable) begin
        open = 0; lgood = 0; m_lock = 0;
      end else if (open == 0) begin
        if (re && fe) emit(0, 0);
        else if (re || fe) begin
          open = re ? 1 : -1;
          t_open = now;
        end
      end else begin
        lead_e = (open > 0) ? re : fe;
        lag_e  = (open > 0) ? fe : re;
        el = now - t_open;
        if (el > SAT) el = SAT;
        if (lag_e) begin
          emit(open * el, 0);
          if (lead_e) t_open = now;
          else open = 0;
        end else if (lead_e) begin
          emit(open * SAT, 1);
          t_open = now;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("flagu", int'(bus.flagu), int'(open > 0));
      chk("flagd", int'(bus.flagd), int'(open < 0));
      chk("err_level", int'(bus.err), m_err);
      chk("lock_level", int'(bus.lock), int'(m_lock));
      chk("err_valid", int'(bus.err_valid), int'(sbq.size() > 0));
      if (bus.err_valid && sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("err_strobe", int'(bus.err), mon_e.e);
        chk("slip_strobe", int'(bus.slip), int'(mon_e.s));
        chk("lock_strobe", int'(bus.lock), int'(mon_e.l));
      end else begin
        chk("slip_quiet", int'(bus.slip), 0);
        sbq.delete();
      end
    end
  end

  task automatic tick(bit r, bit f);
    @(negedge clk);
    bus.ref_in = r;
    bus.fb_in  = f;
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 0);
  endtask

  task automatic pair(int lead, int period);
    int rs, fs;
    rs = (lead >= 0) ? 0 : -lead;
    fs = (lead >= 0) ? lead : 0;
    for (int c = 0; c < period; c++)
      tick(c >= rs && c < rs + 3, c >= fs && c < fs + 3);
  endtask

  task automatic pulse(bit is_ref, int period);
    for (int c = 0; c < period; c++)
      tick(is_ref && c < 3, !is_ref && c < 3);
  endtask

  task automatic outs_zero(string tag);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_valid"}, int'(bus.err_valid), 0);
    chk({tag, "_flagu"}, int'(bus.flagu), 0);
    chk({tag, "_flagd"}, int'(bus.flagd), 0);
    chk({tag, "_slip"}, int'(bus.slip), 0);
    chk({tag, "_lock"}, int'(bus.lock), 0);
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.ref_in = 1'b0;
    bus.fb_in  = 1'b0;
    #1 rst_n = 1'b0;
    #11 outs_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(6);

    repeat (20) pair(5, 40);
    chk("lock_after_plus5", int'(bus.lock), 0);

    repeat (16) pair(-1, 20);
    chk("lock_after_16", int'(bus.lock), 1);
    pair(-4, 20);
    chk("lock_after_big", int'(bus.lock), 0);

    repeat (3) pair(0, 20);

    repeat (40) pair(int'($urandom_range(0, 20)) - 10, 30);

    repeat (6) pulse(1, 30);
    pulse(0, 30);
    pair(int'($urandom_range(128, 190)), 200);
    repeat (4) pulse(0, 30);
    pulse(1, 30);

    pulse(1, 5);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("disable_flagu", int'(bus.flagu), 0);
    idle(2);
    pulse(0, 12);
    bus.enable = 1'b1;
    idle(5);
    pair(3, 20);

    pulse(0, 8);
    chk("pre_reset_flagd", int'(bus.flagd), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 outs_zero("async_reset");
    idle(3);
    rst_n = 1'b1;
    idle(4);
    pair(3, 20);
    chk("post_reset_err", int'(bus.err), 3);

    repeat (30) pair(int'($urandom_range(0, 16)) - 8, 25);
    idle(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pfd_tdc.md
# pfd_tdc

Clocked phase/frequency detector with an integrated counter-based time-to-digital converter for the ADPLL loop. It samples the reference (`ref_in`) and feedback (`fb_in`) clocks on the system clock and measures the signed time between their rising edges in `clk` cycles. Each comparison produces one saturated error word per reference/feedback pair for the digital loop filter. It also provides UP/DN flags, cycle-slip detection and a lock indicator.

## Interface
- `CNT_W`, 8: width of signed error word `err`; magnitude saturates at 2^(CNT_W-1)-1.
- `SYNC_STAGES`, 2: synchroniser flops per input (legal range ≥2).
- `LOCK_TOL`, 2: maximum |err| counted as in-lock.
- `LOCK_CNT`, 16: consecutive in-tolerance measurements required to assert `lock` (legal range ≥1).
- `clk`  in  1  system/DCO sampling clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  synchronous enable; 0 = clear and hold idle.
- `ref_in`  in  1  reference clock, asynchronous to `clk`.
- `fb_in`  in  1  divided feedback clock, asynchronous to `clk`.
- `flagu`  out  1  high while the reference leads (state UP).
- `flagd`  out  1  high while the feedback leads (state DN).
- `err`  out  CNT_W  signed phase error in `clk` cycles (+ = reference leads).
- `err_valid`  out  1  one-cycle strobe: `err` updated this cycle.
- `slip`  out  1  one-cycle strobe: second leading edge arrived before the lagging edge.
- `lock`  out  1  lock indicator.

## Operation
- Reset (`rst_n`=0, async): state IDLE, cnt=0, `err`=0, `err_valid`=0, `slip`=0, `flagu`=0, `flagd`=0, `lock`=0, lock counter=0, synchroniser flops=0.
- Input path: each input passes through SYNC_STAGES flops, then one edge-detect flop. `r_rise` = last sync stage & ~edge flop. `f_rise` is formed the same way.
- State IDLE:
  - `r_rise` & `f_rise` → emit err=0, stay IDLE.
  - `r_rise` only → UP, cnt=1.
  - `f_rise` only → DN, cnt=1.
- State UP (`flagu`=1):
  - no edge → cnt = min(cnt+1, 2^(CNT_W-1)-1).
  - `f_rise` only → emit err=+cnt, go IDLE.
  - `r_rise` only (slip) → emit err=+(2^(CNT_W-1)-1), `slip`=1, stay UP, cnt=1.
  - `r_rise` & `f_rise` together → emit err=+cnt, stay UP, cnt=1. This closes the current window and opens a new one.
- State DN: mirror of UP with the roles of `r_rise`/`f_rise` swapped and negative sign.
  - Negative saturation is -(2^(CNT_W-1)-1); the error range is symmetric and the most-negative code is never produced.
- "Emit" means `err` is registered and `err_valid`=1 for exactly one cycle. `err` holds its value between strobes.
- `flagu`/`flagd` are registered decodes of the next state, so they are never both 1.
- Lock detector, updated only on `err_valid`:
  - |err| ≤ LOCK_TOL and no slip → lock counter = min(counter+1, LOCK_CNT); `lock`=1 when the counter reaches LOCK_CNT.
  - Otherwise → counter=0, `lock`=0 in the same cycle the `err_valid` strobe is registered.
- `enable`=0 (synchronous): state IDLE, cnt=0, flags=0, `err_valid`=0, `slip`=0, lock counter=0, `lock`=0. `err` holds. Synchronisers keep running, so an edge already in flight is detected normally after re-enable.

## Timing
- Pin-to-detect latency is SYNC_STAGES+1 `clk` edges. This latency is identical on both inputs and therefore cancels in `err`.
- Resolution is 1 `clk` period, with ±1 cycle quantisation from asynchronous sampling.
- If `r_rise` is detected at edge t and `f_rise` at edge t+k (1 ≤ k < 2^(CNT_W-1)-1), then `err`=+k and `err_valid` are visible after edge t+k.
- `lock` changes at the same edge as the `err_valid` strobe that causes the change.
- Input pulses high or low for less than 2 `clk` periods are not guaranteed to be detected.
- Reset deassertion mid-window: FSM starts in IDLE. The first edge after reset opens a window; there is no spurious `err_valid`.

## Test plan
- Reference leads by 5 cycles, period 40 cycles, 20 pairs → `err`=+5 each strobe, `flagu` high for 5 cycles per pair, `lock`=0 throughout (5 > LOCK_TOL).
- Feedback leads by 1 cycle for 16 pairs → `err`=-1 each strobe; `lock` rises on the 16th strobe. One 4-cycle error follows → `lock` falls on that strobe.
- Coincident edges (same `clk` sample) → `err`=0, `err_valid`=1, no flag pulse.
- Feedback stopped, reference running with period 30 (CNT_W=8) → `slip`=1 with `err`=+127 every reference edge after the first. An 8-bit lag >127 cycles saturates at +127.
- Drop `enable` mid-UP window, then reassert → flags clear immediately, no `err_valid` for that window, measurement resumes at the next reference edge.
- Assert `rst_n`=0 asynchronously mid-DN window → all outputs 0 immediately. After release, the first pair with a 3-cycle reference lead gives `err`=+3.
